// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed common-anode 7-segment driver for a packed BCD word, with a
// blank interval at the start of each slot. Define BCD_7SEG_SCAN_LZB_EN for leading-zero blanking.
module bcd_7seg_scan #(
    parameter int DIGITS    = 2,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   BCD,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            SEG,
    output logic                  FRAME
);

    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NSLOT = 1 << IW;

    logic [4*DIGITS-1:0] shadow_q;
    logic [PW-1:0]       presc_q;
    logic [IW-1:0]       idx_q;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;
    logic                frame_q;

    logic [3:0]          digit [NSLOT];
    logic [NSLOT-1:0]    lz_blank;
    logic                in_blank;
    logic                presc_wrap;
    logic                idx_wrap;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_d;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Index space is padded to a power of two so digit[idx_q] is always in range.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_digit
            if (gi < DIGITS) begin : g_real
                assign digit[gi] = shadow_q[4*gi +: 4];
            end else begin : g_pad
                assign digit[gi] = 4'h0;
            end
        end
    endgenerate

`ifdef BCD_7SEG_SCAN_LZB_EN
    logic [DIGITS-1:1] digit_zero;
    logic [DIGITS-1:1] zero_above;

    // zero_above[i]: digit i and every higher digit are 0 (illegal nibbles are non-zero).
    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
            assign digit_zero[gi] = (digit[gi] == 4'h0);
            if (gi == DIGITS - 1) begin : g_top
                assign zero_above[gi] = digit_zero[gi];
            end else begin : g_mid
                assign zero_above[gi] = digit_zero[gi] & zero_above[gi+1];
            end
        end
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_lzmask
            if (gi == 0 || gi >= DIGITS) begin : g_never
                assign lz_blank[gi] = 1'b0;
            end else begin : g_chk
                assign lz_blank[gi] = zero_above[gi];
            end
        end
    endgenerate
`else
    assign lz_blank = '0;
`endif

    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (presc_q < PW'(BLANK_CYC));
        end
    endgenerate

    assign presc_wrap = (presc_q == PW'(PRESCALE - 1));
    assign idx_wrap   = (idx_q == IW'(DIGITS - 1));

    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        if (!in_blank) begin
            an_d = ~(DIGITS'(1) << idx_q);
            if (!lz_blank[idx_q]) begin
                seg_d = decode(digit[idx_q]);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_q <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            an_q     <= '1;
            seg_q    <= 7'h7F;
            frame_q  <= 1'b0;
        end else begin
            if (LOAD) begin
                shadow_q <= BCD;
            end
            if (presc_wrap) begin
                presc_q <= '0;
                idx_q   <= idx_wrap ? '0 : idx_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= presc_wrap && idx_wrap;
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign FRAME = frame_q;

endmodule
